// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - opcodes, FSM states and instruction field positions for mcu_core
package mcu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDIN = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LDK  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_RSVD = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 4;
    localparam int BANK_BIT = 3;
    localparam int IMM_MSB  = 3;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/mcu_alu.sv
// rtl/mcu_alu.sv - combinational accumulator ALU; non-carry ops pass carry_i through
module mcu_alu
    import mcu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              carry_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
    assign diff = {1'b0, acc_i} - {1'b0, operand_i};

    always_comb begin
        result_o = acc_i;
        carry_o  = carry_i;
        case (op_i)
            OP_LDIN, OP_LD, OP_LDK: result_o = operand_i;
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            // The extra MSB of the widened difference is the borrow.
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND: result_o = acc_i & operand_i;
            OP_XOR: result_o = acc_i ^ operand_i;
            OP_SHL: begin
                result_o = {acc_i[DATA_W-2:0], 1'b0};
                carry_o  = acc_i[DATA_W-1];
            end
            default: ;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/mcu_core.sv
// rtl/mcu_core.sv - two-phase fetch/execute 8-bit-instruction core; `define BRANCH_EN enables JZ/JC
module mcu_core
    import mcu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr,
    input  logic [DATA_W-1:0] move_in,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] out_sys,
    output logic              out_valid,
    output logic              halted
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] regs_q [NREG];

    logic [3:0]        opcode;
    logic [IDX_W-1:0]  reg_idx;
    logic [DATA_W-1:0] reg_rd;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;
    logic              reg_we;

    assign opcode   = ir_q[OPC_MSB:OPC_LSB];
    assign reg_idx  = ir_q[IDX_W-1:0];
    assign reg_rd   = regs_q[reg_idx];
    assign imm_data = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
    assign imm_addr = ADDR_W'(ir_q[IMM_MSB:IMM_LSB]);

    always_comb begin
        case (opcode)
            OP_LDIN: operand = move_in;
            OP_LDK:  operand = imm_data;
            default: operand = reg_rd;
        endcase
    end

    mcu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i      (opcode),
        .acc_i     (acc_q),
        .operand_i (operand),
        .carry_i   (c_q),
        .result_o  (alu_res),
        .carry_o   (alu_c),
        .zero_o    (alu_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[reg_idx] <= acc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        c_d     = c_q;
        z_d     = z_q;
        out_d   = out_q;
        valid_d = 1'b0;
        reg_we  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + ADDR_W'(1);
                case (opcode)
                    OP_LDIN, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LDK, OP_SHL: begin
                        acc_d = alu_res;
                        c_d   = alu_c;
                        z_d   = alu_z;
                    end
                    OP_ST: begin
                        reg_we = 1'b1;
                        if (ir_q[BANK_BIT]) begin
                            out_d   = acc_q;
                            valid_d = 1'b1;
                        end
                    end
                    OP_JMP: pc_d = imm_addr;
`ifdef BRANCH_EN
                    OP_JZ: if (z_q) pc_d = imm_addr;
                    OP_JC: if (c_q) pc_d = imm_addr;
`endif
                    OP_OUT: begin
                        out_d   = acc_q;
                        valid_d = 1'b1;
                    end
                    // PC parks on the HALT address so instr_addr stays there.
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign instr_addr = pc_q;
    assign out_sys    = out_q;
    assign out_valid  = valid_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_mcu_core.sv
// tb/tb_mcu_core.sv - directed table-driven and sequence checks for mcu_core
module tb_mcu_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic [7:0] move_in;
    logic [3:0] instr_addr;
    logic [7:0] out_sys;
    logic       out_valid;
    logic       halted;

    logic [7:0] prog [16];
    logic [7:0] seen [$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] mi;
        logic [3:0] k;
        logic       src_in;
        logic [3:0] op;
        logic [7:0] exp_out;
        logic       exp_c;
    } vec_t;

    vec_t vecs [15];

    assign instr = prog[instr_addr];

    mcu_core dut (
        .clk        (clk),
        .rst        (rst_n),
        .instr      (instr),
        .move_in    (move_in),
        .instr_addr (instr_addr),
        .out_sys    (out_sys),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_halt(input string nm, input int max_cyc);
        int n;
        n = 0;
        seen.delete();
        while (!halted && n < max_cyc) begin
            step();
            if (out_valid) seen.push_back(out_sys);
            n++;
        end
        check({nm, " halt reached"}, {31'd0, halted}, 32'd1);
    endtask

    function automatic vec_t mk(input logic [7:0] mi, input logic [3:0] k, input logic src_in,
                                input logic [3:0] op, input logic [7:0] exp_out, input logic exp_c);
        vec_t v;
        v.mi = mi; v.k = k; v.src_in = src_in; v.op = op; v.exp_out = exp_out; v.exp_c = exp_c;
        return v;
    endfunction

    initial begin
        int exp_n;
        int exp_addr;
        logic [31:0] first;
        logic bad;

        rst_n   = 1'b0;
        move_in = 8'h00;
        clear_prog();

        // acc starts from k (or move_in), r1 = move_in; op r1; OUT; JC to a second OUT
        vecs[0]  = mk(8'h10, 4'h3, 1'b0, 4'h4, 8'h13, 1'b0);
        vecs[1]  = mk(8'hFE, 4'h5, 1'b0, 4'h4, 8'h03, 1'b1);
        vecs[2]  = mk(8'h80, 4'h0, 1'b1, 4'h4, 8'h00, 1'b1);
        vecs[3]  = mk(8'h03, 4'h5, 1'b0, 4'h5, 8'h02, 1'b0);
        vecs[4]  = mk(8'h05, 4'h3, 1'b0, 4'h5, 8'hFE, 1'b1);
        vecs[5]  = mk(8'h04, 4'h4, 1'b0, 4'h5, 8'h00, 1'b0);
        vecs[6]  = mk(8'h5A, 4'hF, 1'b0, 4'h6, 8'h0A, 1'b0);
        vecs[7]  = mk(8'h5A, 4'hF, 1'b0, 4'h7, 8'h55, 1'b0);
        vecs[8]  = mk(8'h81, 4'h0, 1'b1, 4'h9, 8'h02, 1'b1);
        vecs[9]  = mk(8'h00, 4'h9, 1'b0, 4'h9, 8'h12, 1'b0);
        vecs[10] = mk(8'h77, 4'h1, 1'b0, 4'h2, 8'h77, 1'b0);
        vecs[11] = mk(8'h33, 4'h6, 1'b0, 4'h1, 8'h33, 1'b0);
        vecs[12] = mk(8'h44, 4'h6, 1'b0, 4'h8, 8'h01, 1'b0);
        vecs[13] = mk(8'h44, 4'h6, 1'b0, 4'hE, 8'h06, 1'b0);
        vecs[14] = mk(8'h44, 4'h6, 1'b0, 4'h0, 8'h06, 1'b0);

        // Basic: LDK 5; OUT; HALT
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'hD0; prog[2] = 8'hF0;
        do_reset();
        check("reset instr_addr", instr_addr, 0);
        check("reset out_sys", out_sys, 0);
        check("reset out_valid", out_valid, 0);
        check("reset halted", halted, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_addr = (k < 2) ? 0 : (k < 4) ? 1 : 2;
            check($sformatf("basic c%0d instr_addr", k), instr_addr, exp_addr);
            check($sformatf("basic c%0d out_valid", k), out_valid, (k == 4));
            check($sformatf("basic c%0d halted", k), halted, (k >= 6));
            if (k == 4) check("basic out_sys", out_sys, 8'h05);
        end

        // Table-driven ALU vectors
        for (int i = 0; i < 15; i++) begin
            clear_prog();
            move_in = vecs[i].mi;
            prog[0] = 8'h10;
            prog[1] = 8'h31;
            prog[2] = vecs[i].src_in ? 8'h10 : {4'h8, vecs[i].k};
            prog[3] = {vecs[i].op, 4'h1};
            prog[4] = 8'hD0;
            prog[5] = 8'hC8;
            prog[6] = 8'hF0;
            prog[8] = 8'hD0;
            prog[9] = 8'hF0;
            do_reset();
            run_until_halt($sformatf("vec%0d", i), 100);
`ifdef BRANCH_EN
            exp_n = vecs[i].exp_c ? 2 : 1;
`else
            exp_n = 1;
`endif
            check($sformatf("vec%0d pulses", i), seen.size(), exp_n);
            first = (seen.size() > 0) ? {24'd0, seen[0]} : 32'hDEAD;
            check($sformatf("vec%0d out_sys", i), first, vecs[i].exp_out);
        end

        // ADD carry/zero then JZ
        clear_prog();
        move_in = 8'hFF;
        prog[0] = 8'h10; prog[1] = 8'h30; prog[2] = 8'h81; prog[3] = 8'h40;
        prog[4] = 8'hB7; prog[5] = 8'hD0; prog[6] = 8'hA0; prog[7] = 8'hF0;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
`ifdef BRANCH_EN
            check($sformatf("jz c%0d out_valid", k), out_valid, 0);
`else
            check($sformatf("jz c%0d out_valid", k), out_valid, (k == 12));
`endif
        end
`ifdef BRANCH_EN
        check("jz halted", halted, 1);
        check("jz instr_addr", instr_addr, 7);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid || !halted) bad = 1'b1;
        end
        check("jz stays halted silent", bad, 0);
`else
        check("jz fallthrough out_sys", out_sys, 8'h00);
        check("jz fallthrough halted", halted, 0);
`endif

        // ST with bank flag, then ST without
        clear_prog();
        prog[0] = 8'h89; prog[1] = 8'h3B; prog[2] = 8'h80; prog[3] = 8'h23; prog[4] = 8'hD0;
        prog[5] = 8'h86; prog[6] = 8'h33; prog[7] = 8'h80; prog[8] = 8'h23; prog[9] = 8'hD0;
        prog[10] = 8'hF0;
        do_reset();
        run_until_halt("st", 100);
        check("st pulses", seen.size(), 3);
        for (int j = 0; j < 3; j++) begin
            first = (seen.size() > j) ? {24'd0, seen[j]} : 32'hDEAD;
            check($sformatf("st pulse%0d", j), first, (j < 2) ? 8'h09 : 8'h06);
        end

        // PC wrap on all-NOP program
        clear_prog();
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k % 2 == 0) check($sformatf("wrap c%0d instr_addr", k), instr_addr, (k / 2) % 16);
        end

        // JMP 0xF from addr 3, then wrap to 0
        clear_prog();
        prog[3] = 8'hAF;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) check("jmp before", instr_addr, 3);
            if (k == 8) check("jmp target", instr_addr, 15);
            if (k == 10) check("jmp wrap", instr_addr, 0);
        end

        // Async reset during EXEC of OUT
        clear_prog();
        move_in = 8'h7A;
        prog[0] = 8'h10; prog[1] = 8'hD0; prog[2] = 8'hF0;
        do_reset();
        step(); step(); step();
        check("areset pre instr_addr", instr_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset instr_addr", instr_addr, 0);
        check("areset out_sys", out_sys, 0);
        check("areset out_valid", out_valid, 0);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (out_sys == 8'h7A || out_valid) bad = 1'b1;
        end
        check("areset no 7A in reset", bad, 0);
        move_in = 8'h11;
        @(negedge clk);
        rst_n = 1'b1;
        run_until_halt("areset rerun", 100);
        check("areset rerun pulses", seen.size(), 1);
        first = (seen.size() > 0) ? {24'd0, seen[0]} : 32'hDEAD;
        check("areset rerun out_sys", first, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_core.md
# mcu_core

Parametrised successor to the fixed 2-bit-address sequencer top level. It is a two-phase (fetch/execute) 8-bit-instruction microcontroller core. It has a DATA_W accumulator, an NREG-entry scratch register file, carry/zero flags, a registered system output port with a valid strobe, and optional conditional branching. Program memory is external: the core drives `instr_addr` and samples `instr` combinationally.

## Interface
- ADDR_W, 4, program counter width; program depth 2^ADDR_W
- DATA_W, 8, accumulator/register/IO width (≥4)
- NREG, 8, scratch registers (power of two, 2..8); index = instr[2:0] truncated to log2(NREG)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- instr  input  8  instruction at `instr_addr`: [7:4] opcode, [3] bank flag, [2:0] index/immediate low bits
- move_in  input  DATA_W  external input operand
- instr_addr  output  ADDR_W  program counter
- out_sys  output  DATA_W  registered system output
- out_valid  output  1  one-cycle strobe on each `out_sys` update
- halted  output  1  core is in HALT

## Operation
- FSM states:
  - FETCH: IR ← instr; go to EXEC.
  - EXEC: execute IR; PC ← PC+1 unless a jump is taken; go to FETCH, or to HALT on opcode F.
  - HALT: absorbing; only rst leaves it.
- imm4 = {instr[3], instr[2:0]}, zero-extended to DATA_W / truncated to ADDR_W.
- Opcodes (Z = acc==0 after the write):
  - 0 NOP.
  - 1 LDIN: acc ← move_in; Z.
  - 2 LD: acc ← reg[idx]; Z.
  - 3 ST: reg[idx] ← acc; if bank flag=1, also out_sys ← acc with strobe.
  - 4 ADD: {C,acc} ← acc+reg[idx]; Z.
  - 5 SUB: acc ← acc−reg[idx]; C = borrow; Z.
  - 6 AND, 7 XOR: acc ← acc op reg[idx]; C unchanged; Z.
  - 8 LDK: acc ← imm4; Z.
  - 9 SHL: C ← acc[MSB]; acc ← acc<<1; Z.
  - A JMP: PC ← imm4.
  - B JZ: if Z, PC ← imm4.
  - C JC: if C, PC ← imm4.
  - D OUT: out_sys ← acc; strobe.
  - E reserved: executes as NOP.
  - F HALT.
- Flag rules: JMP/JZ/JC/ST/OUT/NOP do not alter flags. Z/C evaluate the state at EXEC entry.
- PC wraps 2^ADDR_W−1 → 0 silently.
- Arithmetic is modulo 2^DATA_W; no overflow flag.

## Timing
- Reset values: PC=0, state=FETCH, IR=0, acc=0, all regs=0, C=Z=0, out_sys=0, out_valid=0, halted=0.
- Reset takes effect immediately, including mid-EXEC. A pending register write, output write, or jump is discarded.
- Two cycles per instruction. `instr_addr` changes only at the EXEC→FETCH edge.
- out_sys/out_valid update on the clock edge ending the EXEC of OUT or ST with bank flag=1. out_valid is high exactly one cycle.
- Register write and read of the same register: a read in the next instruction sees the new value.
- halted rises on the edge ending EXEC of HALT. instr_addr then holds the HALT address; outputs hold.

## Configuration
- BRANCH_EN defined: JZ and JC behave as above.
- BRANCH_EN undefined: opcodes B and C execute as NOP (PC+1, flags unchanged). JMP remains. No branch-condition logic is synthesised.

## Structure
- Package mcu_pkg:
  - opcode localparams (OP_NOP … OP_HALT);
  - FSM state enum/encoding (ST_FETCH, ST_EXEC, ST_HALT);
  - instruction field slice constants.
- Sub-module mcu_alu: combinational.
  - Inputs: op, acc, operand, carry-in.
  - Outputs: result, carry-out, zero.
  - Used by the core for opcodes 1,2,4–9.
- Register file and FSM live in mcu_core.

## Test plan
- Reset/basic output (defaults): program LDK 5; OUT; HALT.
  - After rst release, instr_addr=0 and out_sys=0.
  - out_sys=0x05 with a single out_valid pulse at the end of cycle 4.
  - halted=1 from cycle 6 on; instr_addr stays 2.
- ADD carry/zero: move_in=0xFF; program LDIN; ST r0; LDK 1; ADD r0; JZ 7; OUT at addr 5; HALT at 7.
  - With BRANCH_EN: acc=0x00, C=1, Z=1; jumps to 7; no out_valid ever.
- Same program without BRANCH_EN:
  - JZ falls through; OUT fires with out_sys=0x00; HALT is never reached before wrap.
  - Check out_valid at the addr-5 EXEC.
- ST bank flag: LDK 9; ST r3 with instr[3]=1 (0x3B); LD r3; OUT.
  - Two out_valid pulses, both with out_sys=0x09.
  - Also check `instr=0x33` writes r3 without a strobe.
- PC wrap (ADDR_W=4): all-NOP program.
  - instr_addr runs 0…15 then 0 at cycle 33.
  - JMP 0xF from addr 3 lands on 15.
- Async reset mid-EXEC of OUT (acc=0x7A): drop rst during EXEC.
  - instr_addr=0, out_sys=0, and out_valid=0 immediately.
  - No 0x7A ever appears on out_sys.
